// File: rtl/usb3_ep_in_writer_pkg.sv
// Shared constants and types for the USB3 endpoint IN writer.
package usb3_ep_in_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_COMMIT,
        ST_ACK_WAIT
    } state_t;

    localparam int unsigned MAX_PKT_BYTES = 1024;

    // s_keep on the last word: 0 means all four bytes are valid
    localparam logic [1:0] KEEP_ALL = 2'd0;

endpackage

// File: rtl/usb3_ep_in_writer_if.sv
// Valid/ready 32-bit word stream feeding the endpoint IN writer.
interface usb3_ep_in_writer_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;
    logic [1:0]  s_keep;

    modport master (output s_data, output s_valid, output s_last, output s_keep, input s_ready);
    modport slave  (input s_data, input s_valid, input s_last, input s_keep, output s_ready);
endinterface

// File: rtl/usb3_ep_in_writer.sv
// Fills one endpoint IN buffer half from the word stream, then commits it with a byte
// length and completes the commit/ack handshake before taking the next half.
module usb3_ep_in_writer
    import usb3_ep_in_writer_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 256,
    parameter int unsigned TIMEOUT   = 4095
) (
    input  logic                  local_clk,
    input  logic                  reset_n,
    usb3_ep_in_writer_if.slave    s,
    input  logic                  flush,
    output logic [8:0]            buf_in_addr,
    output logic [31:0]           buf_in_data,
    output logic                  buf_in_wren,
    input  logic                  buf_in_ready,
    output logic                  buf_in_commit,
    output logic [10:0]           buf_in_commit_len,
    input  logic                  buf_in_commit_ack,
    output logic                  busy,
    output logic [15:0]           pkt_count
);

    state_t      state;
    logic [8:0]  wc;
    logic [15:0] timer;

    logic        accept;
    logic [8:0]  wc_next;
    logic        hit_full;
    logic        hit_last;
    logic        hit_timeout;
    logic        exit_fill;

    function automatic logic [10:0] pkt_len(input logic [8:0] words, input logic last,
                                            input logic [1:0] keep);
        logic [10:0] bytes;
        bytes = {words, 2'b00};
        if (last && keep != KEEP_ALL)
            bytes = bytes - (11'd4 - {9'd0, keep});
        return bytes;
    endfunction

    assign s.s_ready   = (state == ST_FILL);
    assign busy        = (state != ST_IDLE);
    assign accept      = s.s_valid & s.s_ready;
    assign wc_next     = wc + {8'd0, accept};
    assign hit_full    = accept && (wc_next == 9'(MAX_WORDS));
    assign hit_last    = accept && s.s_last;
    assign hit_timeout = (TIMEOUT != 0) && !accept && (wc != '0) && (timer == 16'(TIMEOUT - 1));
    assign exit_fill   = (state == ST_FILL) && (hit_full || hit_last || flush || hit_timeout);

    always_ff @(posedge local_clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= ST_IDLE;
            wc                <= '0;
            timer             <= '0;
            buf_in_addr       <= '0;
            buf_in_data       <= '0;
            buf_in_wren       <= 1'b0;
            buf_in_commit     <= 1'b0;
            buf_in_commit_len <= '0;
            pkt_count         <= '0;
        end else begin
            buf_in_wren <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (buf_in_ready && !buf_in_commit_ack) begin
                        state <= ST_FILL;
                        wc    <= '0;
                        timer <= '0;
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        buf_in_wren <= 1'b1;
                        buf_in_addr <= wc;
                        buf_in_data <= s.s_data;
                        wc          <= wc_next;
                        timer       <= '0;
                    end else if (wc != '0) begin
                        timer <= timer + 16'd1;
                    end
                    if (exit_fill) begin
                        state             <= ST_COMMIT;
                        buf_in_commit_len <= pkt_len(wc_next, hit_last, s.s_keep);
                        // An accepting exit still has its write in flight; commit waits one cycle
                        buf_in_commit     <= !accept;
                    end
                end
                ST_COMMIT: begin
                    buf_in_commit <= 1'b1;
                    if (buf_in_commit && buf_in_commit_ack) begin
                        buf_in_commit <= 1'b0;
                        pkt_count     <= pkt_count + 16'd1;
                        state         <= ST_ACK_WAIT;
                    end
                end
                ST_ACK_WAIT: begin
                    if (!buf_in_commit_ack)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb3_ep_in_writer.sv
// Directed bench for usb3_ep_in_writer with a hand-driven endpoint (ready/ack).
module tb_usb3_ep_in_writer;

    logic        local_clk = 1'b0;
    logic        reset_n   = 1'b1;
    logic        flush     = 1'b0;
    logic [8:0]  buf_in_addr;
    logic [31:0] buf_in_data;
    logic        buf_in_wren;
    logic        buf_in_ready = 1'b0;
    logic        buf_in_commit;
    logic [10:0] buf_in_commit_len;
    logic        buf_in_commit_ack = 1'b0;
    logic        busy;
    logic [15:0] pkt_count;

    int vectors    = 0;
    int miscompares = 0;
    int n;

    usb3_ep_in_writer_if sif ();

    usb3_ep_in_writer #(.MAX_WORDS(256), .TIMEOUT(16)) dut (
        .local_clk         (local_clk),
        .reset_n           (reset_n),
        .s                 (sif.slave),
        .flush             (flush),
        .buf_in_addr       (buf_in_addr),
        .buf_in_data       (buf_in_data),
        .buf_in_wren       (buf_in_wren),
        .buf_in_ready      (buf_in_ready),
        .buf_in_commit     (buf_in_commit),
        .buf_in_commit_len (buf_in_commit_len),
        .buf_in_commit_ack (buf_in_commit_ack),
        .busy              (busy),
        .pkt_count         (pkt_count)
    );

    always #5 local_clk = ~local_clk;

    task automatic tick();
        @(posedge local_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic last, input logic [1:0] keep,
                        input logic fl, input logic [8:0] exp_addr);
        sif.s_valid = 1'b1;
        sif.s_data  = d;
        sif.s_last  = last;
        sif.s_keep  = keep;
        flush       = fl;
        tick();
        chk("wren", {31'd0, buf_in_wren}, 32'd1);
        chk("addr", {23'd0, buf_in_addr}, {23'd0, exp_addr});
        chk("data", buf_in_data, d);
    endtask

    task automatic idle_stream();
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        sif.s_keep  = 2'd0;
        flush       = 1'b0;
    endtask

    task automatic wait_commit(input int limit, output int cycles);
        cycles = 0;
        while (!buf_in_commit && cycles < limit) begin
            tick();
            cycles++;
        end
        chk("commit_seen", {31'd0, buf_in_commit}, 32'd1);
    endtask

    task automatic do_ack(input logic [15:0] exp_pkts);
        buf_in_commit_ack = 1'b1;
        tick();
        chk("commit_drop", {31'd0, buf_in_commit}, 32'd0);
        chk("pkt_count", {16'd0, pkt_count}, {16'd0, exp_pkts});
        buf_in_commit_ack = 1'b0;
        tick();
        chk("idle_after_ack", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        sif.s_data = '0;
        idle_stream();

        // Reset state
        #2 reset_n = 1'b0;
        tick();
        tick();
        chk("rst_wren", {31'd0, buf_in_wren}, 32'd0);
        chk("rst_commit", {31'd0, buf_in_commit}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pkts", {16'd0, pkt_count}, 32'd0);
        chk("rst_sready", {31'd0, sif.s_ready}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Full packet: 256 words 0..255
        buf_in_ready = 1'b1;
        tick();
        chk("fill_sready", {31'd0, sif.s_ready}, 32'd1);
        for (int i = 0; i < 256; i++)
            send(32'(i), 1'b0, 2'd0, 1'b0, 9'(i));
        idle_stream();
        chk("full_no_sready", {31'd0, sif.s_ready}, 32'd0);
        chk("full_commit_after_wren", {31'd0, buf_in_commit}, 32'd0);
        wait_commit(8, n);
        chk("full_commit_lat", 32'(n), 32'd1);
        chk("full_len", {21'd0, buf_in_commit_len}, 32'd1024);
        do_ack(16'd1);

        // Short last word: 5 words, keep=2
        tick();
        for (int i = 0; i < 5; i++)
            send(32'hA000 + 32'(i), (i == 4), 2'd2, 1'b0, 9'(i));
        sif.s_last = 1'b0;
        sif.s_data = 32'hDEAD;
        wait_commit(8, n);
        chk("short_len", {21'd0, buf_in_commit_len}, 32'd18);
        chk("short_no_accept_sready", {31'd0, sif.s_ready}, 32'd0);
        chk("short_no_wren", {31'd0, buf_in_wren}, 32'd0);
        idle_stream();
        do_ack(16'd2);

        // Idle timeout after 3 words
        tick();
        for (int i = 0; i < 3; i++)
            send(32'hB000 + 32'(i), 1'b0, 2'd0, 1'b0, 9'(i));
        idle_stream();
        wait_commit(40, n);
        chk("timeout_cycles", 32'(n), 32'd16);
        chk("timeout_len", {21'd0, buf_in_commit_len}, 32'd12);
        do_ack(16'd3);

        // Flush with no data: zero-length packet
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("zlp_commit", {31'd0, buf_in_commit}, 32'd1);
        chk("zlp_len", {21'd0, buf_in_commit_len}, 32'd0);
        buf_in_commit_ack = 1'b1;
        tick();
        chk("zlp_pkts", {16'd0, pkt_count}, 32'd4);
        buf_in_commit_ack = 1'b0;
        buf_in_ready = 1'b0;
        tick();

        // Backpressure: endpoint not ready
        sif.s_valid = 1'b1;
        sif.s_data  = 32'h5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_sready", {31'd0, sif.s_ready}, 32'd0);
            chk("bp_wren", {31'd0, buf_in_wren}, 32'd0);
            chk("bp_busy", {31'd0, busy}, 32'd0);
        end
        buf_in_ready = 1'b1;
        buf_in_commit_ack = 1'b1;
        tick();
        chk("bp_ack_hold", {31'd0, busy}, 32'd0);
        sif.s_valid = 1'b0;
        buf_in_commit_ack = 1'b0;
        tick();
        chk("bp_release", {31'd0, sif.s_ready}, 32'd1);

        // Coincidence: word 256 with last, keep=1 and flush
        for (int i = 0; i < 256; i++)
            send(32'hC000 + 32'(i), (i == 255), 2'd1, (i == 255), 9'(i));
        idle_stream();
        wait_commit(8, n);
        chk("coinc_len", {21'd0, buf_in_commit_len}, 32'd1021);
        do_ack(16'd5);
        buf_in_ready = 1'b0;
        tick();
        tick();
        chk("coinc_single_commit", {31'd0, buf_in_commit}, 32'd0);
        chk("coinc_single_pkts", {16'd0, pkt_count}, 32'd5);

        // Reset in the middle of FILL
        buf_in_ready = 1'b1;
        tick();
        for (int i = 0; i < 10; i++)
            send(32'hD000 + 32'(i), 1'b0, 2'd0, 1'b0, 9'(i));
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_wren", {31'd0, buf_in_wren}, 32'd0);
        chk("mid_rst_addr", {23'd0, buf_in_addr}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_pkts", {16'd0, pkt_count}, 32'd0);
        chk("mid_rst_sready", {31'd0, sif.s_ready}, 32'd0);
        sif.s_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        send(32'h0000ABCD, 1'b0, 2'd0, 1'b0, 9'd0);
        idle_stream();
        tick();
        chk("post_rst_no_commit", {31'd0, buf_in_commit}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
